// File: rtl/clk_en_divider_bank_if.sv
// ---------------------------------------------------------------------------
// clk_en_divider_bank_if
//   Configuration bus for the clock-enable divider bank.
//   Signals:
//     wr_en     one-cycle config write strobe
//     wr_ch     target channel of the write
//     wr_div    divisor to program (0 behaves as 1)
//     wr_ena    channel enable value carried by the write
//     wr_casc   cascade select value carried by the write (ignored for ch 0)
//     sync_clr  restart every channel in phase
//   Modports:
//     master    drives the bus (configuration source / testbench)
//     slave     receives the bus (divider bank)
// ---------------------------------------------------------------------------
interface clk_en_divider_bank_if #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 17
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic             wr_en;
   logic [CH_W-1:0]  wr_ch;
   logic [CNT_W-1:0] wr_div;
   logic             wr_ena;
   logic             wr_casc;
   logic             sync_clr;

   modport master (
      output wr_en, wr_ch, wr_div, wr_ena, wr_casc, sync_clr
   );

   modport slave (
      input  wr_en, wr_ch, wr_div, wr_ena, wr_casc, sync_clr
   );
endinterface

// File: rtl/clk_en_divider_bank.sv
// ---------------------------------------------------------------------------
// clk_en_divider_bank
//   Bank of NUM_CH independent, runtime-programmable clock-enable dividers
//   running entirely on the system clock. Each channel produces a one-cycle
//   tick per period and a 50%-duty square-wave enable. Channel i may count
//   ticks of channel i-1 (cascade) to reach large division ratios.
//   Ports:
//     clk     system clock, rising edge
//     rst     asynchronous active-low reset
//     cfg     configuration bus (slave modport): write strobe, channel,
//             divisor, enable, cascade select, sync_clr
//     tick_o  per-channel one-cycle pulse, registered
//     sq_o    per-channel square wave toggling on each tick, registered
// ---------------------------------------------------------------------------
module clk_en_divider_bank #(
   parameter int NUM_CH  = 4,
   parameter int CNT_W   = 17,
   parameter int DEF_DIV = 100000
) (
   input  logic                      clk,
   input  logic                      rst,
   clk_en_divider_bank_if.slave      cfg,
   output logic [NUM_CH-1:0]         tick_o,
   output logic [NUM_CH-1:0]         sq_o
);
   localparam int               CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [CNT_W-1:0] DEF_DIV_C = CNT_W'(DEF_DIV);
   localparam logic [CNT_W-1:0] ZERO_C    = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

   // Flop outputs of all channels gathered into vectors; the cascade source
   // of channel i is the registered tick of channel i-1.
   logic [NUM_CH-1:0] tick_s;
   logic [NUM_CH-1:0] sq_s;

   assign tick_o = tick_s;
   assign sq_o   = sq_s;

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      localparam bit HAS_SRC_C = (gi > 0);

      logic [CNT_W-1:0] cnt_q,  cnt_d;
      logic [CNT_W-1:0] act_q,  act_d;
      logic [CNT_W-1:0] pend_q, pend_d;
      logic             en_q,   en_d;
      logic             casc_q, casc_d;
      logic             tick_q, tick_d;
      logic             sq_q,   sq_d;
      logic [CNT_W-1:0] new_div_s;
      logic             wr_hit_s;
      logic             src_tick_s;
      logic             adv_s;
      logic             terminal_s;

      if (HAS_SRC_C) begin : g_src
         assign src_tick_s = tick_s[gi-1];
      end else begin : g_nosrc
         assign src_tick_s = 1'b0;
      end

      // An out-of-range wr_ch never matches any channel index, so it is dropped.
      assign wr_hit_s   = cfg.wr_en && (cfg.wr_ch == CH_W'(gi));
      assign new_div_s  = (cfg.wr_div == ZERO_C) ? ONE_C : cfg.wr_div;
      assign adv_s      = en_q && (casc_q ? src_tick_s : 1'b1);
      // act_q is never zero, so act_q-1 cannot wrap.
      assign terminal_s = (cnt_q == (act_q - ONE_C));

      // Next-state: config capture, then sync_clr > enable-edge write > advance.
      always_comb begin
         cnt_d  = cnt_q;
         act_d  = act_q;
         pend_d = pend_q;
         en_d   = en_q;
         casc_d = casc_q;
         tick_d = 1'b0;
         sq_d   = sq_q;

         if (wr_hit_s) begin
            pend_d = new_div_s;
            en_d   = cfg.wr_ena;
            casc_d = HAS_SRC_C ? cfg.wr_casc : 1'b0;
         end else begin
            pend_d = pend_q;
            en_d   = en_q;
            casc_d = casc_q;
         end

         if (cfg.sync_clr) begin
            // pend_d already reflects a same-cycle write to this channel.
            cnt_d  = ZERO_C;
            tick_d = 1'b0;
            sq_d   = 1'b0;
            act_d  = pend_d;
         end else if (wr_hit_s && !(en_q && cfg.wr_ena)) begin
            // Enable edge or write to an idle channel: restart with new divisor.
            cnt_d  = ZERO_C;
            tick_d = 1'b0;
            act_d  = new_div_s;
            if (en_q) begin
               sq_d = 1'b0;
            end else begin
               sq_d = sq_q;
            end
         end else if (adv_s && terminal_s) begin
            // Period completes at the old divisor; the pending one (as it was
            // before any same-edge write) takes over from here.
            cnt_d  = ZERO_C;
            tick_d = 1'b1;
            sq_d   = ~sq_q;
            act_d  = pend_q;
         end else if (adv_s) begin
            cnt_d  = cnt_q + ONE_C;
            tick_d = 1'b0;
         end else begin
            cnt_d  = cnt_q;
            tick_d = 1'b0;
         end
      end

      // Channel state registers with asynchronous active-low reset.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            cnt_q  <= ZERO_C;
            act_q  <= DEF_DIV_C;
            pend_q <= DEF_DIV_C;
            en_q   <= 1'b0;
            casc_q <= 1'b0;
            tick_q <= 1'b0;
            sq_q   <= 1'b0;
         end else begin
            cnt_q  <= cnt_d;
            act_q  <= act_d;
            pend_q <= pend_d;
            en_q   <= en_d;
            casc_q <= casc_d;
            tick_q <= tick_d;
            sq_q   <= sq_d;
         end
      end

      assign tick_s[gi] = tick_q;
      assign sq_s[gi]   = sq_q;
   end
endmodule

// File: tb/tb_clk_en_divider_bank.sv
// ---------------------------------------------------------------------------
// tb_clk_en_divider_bank
//   Self-checking bench for clk_en_divider_bank. Three channels so that an
//   out-of-range channel number (3) is encodable on the 2-bit wr_ch bus.
// ---------------------------------------------------------------------------
module tb_clk_en_divider_bank;
   localparam int NUM_CH  = 3;
   localparam int CNT_W   = 8;
   localparam int DEF_DIV = 20;
   localparam int CH_W    = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [NUM_CH-1:0] tick_o;
   logic [NUM_CH-1:0] sq_o;

   int errors = 0;
   int checks = 0;

   clk_en_divider_bank_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

   clk_en_divider_bank #(
      .NUM_CH (NUM_CH),
      .CNT_W  (CNT_W),
      .DEF_DIV(DEF_DIV)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .cfg    (bus.slave),
      .tick_o (tick_o),
      .sq_o   (sq_o)
   );

   always #5 clk = ~clk;

   // Reference model: each channel has a period length (act), a queued
   // period length (pend) and the number of advances seen in the current
   // period (pos). A tick marks the end of a period.
   int                m_act  [NUM_CH];
   int                m_pend [NUM_CH];
   int                m_pos  [NUM_CH];
   bit                m_en   [NUM_CH];
   bit                m_casc [NUM_CH];
   logic [NUM_CH-1:0] m_tick;
   logic [NUM_CH-1:0] m_sq;

   function automatic void model_reset();
      for (int c = 0; c < NUM_CH; c++) begin
         m_act[c]  = DEF_DIV;
         m_pend[c] = DEF_DIV;
         m_pos[c]  = 0;
         m_en[c]   = 1'b0;
         m_casc[c] = 1'b0;
      end
      m_tick = '0;
      m_sq   = '0;
   endfunction

   function automatic void model_step();
      logic [NUM_CH-1:0] prev;
      bit hit, adv, up;
      int nd, old_pend;
      prev = m_tick;
      for (int c = 0; c < NUM_CH; c++) begin
         hit      = bus.wr_en && (int'(bus.wr_ch) == c);
         nd       = (bus.wr_div == 0) ? 1 : int'(bus.wr_div);
         up       = (c > 0) ? prev[(c > 0) ? c - 1 : 0] : 1'b0;
         adv      = m_en[c] && (!m_casc[c] || up);
         old_pend = m_pend[c];
         m_tick[c] = 1'b0;
         if (hit && !(m_en[c] && bus.wr_ena)) begin
            if (m_en[c]) m_sq[c] = 1'b0;
            m_pos[c] = 0;
            m_act[c] = nd;
         end else if (adv) begin
            m_pos[c] = m_pos[c] + 1;
            if (m_pos[c] == m_act[c]) begin
               m_pos[c]  = 0;
               m_tick[c] = 1'b1;
               m_sq[c]   = ~m_sq[c];
               m_act[c]  = old_pend;
            end
         end
         if (hit) begin
            m_pend[c] = nd;
            m_en[c]   = bus.wr_ena;
            m_casc[c] = (c > 0) && bus.wr_casc;
         end
         if (bus.sync_clr) begin
            m_pos[c]  = 0;
            m_tick[c] = 1'b0;
            m_sq[c]   = 1'b0;
            m_act[c]  = m_pend[c];
         end
      end
   endfunction

   task automatic idle();
      bus.wr_en    = 1'b0;
      bus.wr_ch    = '0;
      bus.wr_div   = '0;
      bus.wr_ena   = 1'b0;
      bus.wr_casc  = 1'b0;
      bus.sync_clr = 1'b0;
   endtask

   task automatic set_write(input int ch, input int div, input bit ena, input bit casc);
      bus.wr_en   = 1'b1;
      bus.wr_ch   = CH_W'(ch);
      bus.wr_div  = CNT_W'(div);
      bus.wr_ena  = ena;
      bus.wr_casc = casc;
   endtask

   // One clock: model follows the DUT edge, then settle to the falling edge.
   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (tick_o !== 3'b000 || sq_o !== 3'b000) begin
         errors++;
         $display("FAIL reset_state tick=%b sq=%b want 000/000", tick_o, sq_o);
      end
      for (int k = 0; k < 6; k++) begin
         cycle();
         checks++;
         if (tick_o !== 3'b000 || sq_o !== 3'b000) begin
            errors++;
            $display("FAIL reset_idle k=%0d tick=%b sq=%b want 000/000", k, tick_o, sq_o);
         end
      end
   endtask

   task automatic test_basic();
      logic et, es;
      do_reset();
      for (int k = 0; k <= 30; k++) begin
         if (k == 0) set_write(0, 5, 1'b1, 1'b0);
         cycle();
         idle();
         et = (k > 0) && (k % 5 == 0);
         es = ((k / 5) % 2) == 1;
         checks++;
         if (tick_o[0] !== et || sq_o[0] !== es) begin
            errors++;
            $display("FAIL basic_div5 k=%0d tick0=%b sq0=%b want %b/%b", k, tick_o[0], sq_o[0], et, es);
         end
         checks++;
         if (tick_o !== m_tick || sq_o !== m_sq) begin
            errors++;
            $display("FAIL basic_model k=%0d tick=%b sq=%b want %b/%b", k, tick_o, sq_o, m_tick, m_sq);
         end
      end
   endtask

   task automatic test_cascade();
      logic e0, e1;
      do_reset();
      for (int k = 0; k <= 40; k++) begin
         if (k == 0) set_write(0, 4, 1'b1, 1'b0);
         if (k == 1) set_write(1, 3, 1'b1, 1'b1);
         cycle();
         idle();
         e0 = (k > 0) && (k % 4 == 0);
         e1 = (k >= 13) && ((k - 13) % 12 == 0);
         checks++;
         if (tick_o[0] !== e0 || tick_o[1] !== e1) begin
            errors++;
            $display("FAIL cascade_ticks k=%0d tick0=%b tick1=%b want %b/%b", k, tick_o[0], tick_o[1], e0, e1);
         end
         checks++;
         if (tick_o !== m_tick || sq_o !== m_sq) begin
            errors++;
            $display("FAIL cascade_model k=%0d tick=%b sq=%b want %b/%b", k, tick_o, sq_o, m_tick, m_sq);
         end
      end
   endtask

   task automatic test_div_change();
      logic et;
      do_reset();
      for (int k = 0; k <= 24; k++) begin
         if (k == 0) set_write(0, 8, 1'b1, 1'b0);
         if (k == 3) set_write(0, 3, 1'b1, 1'b0);
         cycle();
         idle();
         et = (k == 8) || ((k > 8) && ((k - 8) % 3 == 0));
         checks++;
         if (tick_o[0] !== et) begin
            errors++;
            $display("FAIL div_change k=%0d tick0=%b want %b", k, tick_o[0], et);
         end
         checks++;
         if (tick_o !== m_tick || sq_o !== m_sq) begin
            errors++;
            $display("FAIL div_change_model k=%0d tick=%b sq=%b want %b/%b", k, tick_o, sq_o, m_tick, m_sq);
         end
      end
   endtask

   task automatic test_div01();
      logic et, es;
      do_reset();
      for (int k = 0; k <= 14; k++) begin
         if (k == 0) set_write(2, 0, 1'b1, 1'b0);
         if (k == 6) set_write(2, 1, 1'b1, 1'b0);
         cycle();
         idle();
         et = (k >= 1);
         es = (k % 2) == 1;
         checks++;
         if (tick_o[2] !== et || sq_o[2] !== es) begin
            errors++;
            $display("FAIL div01 k=%0d tick2=%b sq2=%b want %b/%b", k, tick_o[2], sq_o[2], et, es);
         end
         checks++;
         if (tick_o !== m_tick || sq_o !== m_sq) begin
            errors++;
            $display("FAIL div01_model k=%0d tick=%b sq=%b want %b/%b", k, tick_o, sq_o, m_tick, m_sq);
         end
      end
   endtask

   task automatic test_sync_clr();
      int divs [NUM_CH];
      int n;
      logic [NUM_CH-1:0] et, es;
      divs[0] = 3;
      divs[1] = 5;
      divs[2] = 4;
      do_reset();
      for (int c = 0; c < NUM_CH; c++) begin
         set_write(c, divs[c], 1'b1, 1'b0);
         cycle();
         idle();
      end
      n = $urandom_range(3, 17);
      for (int k = 0; k < n; k++) cycle();
      checks++;
      if (tick_o !== m_tick || sq_o !== m_sq) begin
         errors++;
         $display("FAIL sync_pre_model tick=%b sq=%b want %b/%b", tick_o, sq_o, m_tick, m_sq);
      end
      for (int k = 0; k <= 30; k++) begin
         if (k == 0) bus.sync_clr = 1'b1;
         cycle();
         idle();
         for (int c = 0; c < NUM_CH; c++) begin
            et[c] = (k > 0) && (k % divs[c] == 0);
            es[c] = ((k / divs[c]) % 2) == 1;
         end
         checks++;
         if (tick_o !== et || sq_o !== es) begin
            errors++;
            $display("FAIL sync_clr_align k=%0d tick=%b sq=%b want %b/%b", k, tick_o, sq_o, et, es);
         end
         checks++;
         if (tick_o !== m_tick || sq_o !== m_sq) begin
            errors++;
            $display("FAIL sync_clr_model k=%0d tick=%b sq=%b want %b/%b", k, tick_o, sq_o, m_tick, m_sq);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic et;
      // Channels are still running from the previous scenario (sq[2] is high).
      checks++;
      if (sq_o !== 3'b100) begin
         errors++;
         $display("FAIL pre_reset_sq sq=%b want 100", sq_o);
      end
      #2;
      rst = 1'b0;
      model_reset();
      #1;
      checks++;
      if (tick_o !== 3'b000 || sq_o !== 3'b000) begin
         errors++;
         $display("FAIL async_reset tick=%b sq=%b want 000/000", tick_o, sq_o);
      end
      @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k <= 15; k++) begin
         if (k == 0) set_write(0, 3, 1'b1, 1'b0);
         if (k == 2) set_write(3, 2, 1'b1, 1'b1);
         cycle();
         idle();
         et = (k > 0) && (k % 3 == 0);
         checks++;
         if (tick_o !== {2'b00, et} || sq_o[2:1] !== 2'b00) begin
            errors++;
            $display("FAIL out_of_range k=%0d tick=%b sq=%b want tick=%b sq[2:1]=00", k, tick_o, sq_o, {2'b00, et});
         end
         checks++;
         if (tick_o !== m_tick || sq_o !== m_sq) begin
            errors++;
            $display("FAIL out_of_range_model k=%0d tick=%b sq=%b want %b/%b", k, tick_o, sq_o, m_tick, m_sq);
         end
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(0, 3) == 0) begin
            set_write($urandom_range(0, 3), $urandom_range(0, 9),
                      $urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1);
         end
         bus.sync_clr = ($urandom_range(0, 39) == 0);
         cycle();
         idle();
         checks++;
         if (tick_o !== m_tick || sq_o !== m_sq) begin
            errors++;
            $display("FAIL random_model k=%0d tick=%b sq=%b want %b/%b", k, tick_o, sq_o, m_tick, m_sq);
         end
      end
   endtask

   initial begin
      rst = 1'b0;
      idle();
      model_reset();
      test_reset();
      test_basic();
      test_cascade();
      test_div_change();
      test_div01();
      test_sync_clr();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
